// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) arbiter in front of a single
// memory port, with at most one memory transaction outstanding.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   i_* / d_*                     requester ports: valid/ready request handshake,
//                                 wen/addr/wdata/wmask request fields,
//                                 rvalid/rdata completion (read data or write ack)
//   mem_ready                     constant 1
//   mem_valid                     one-cycle issue strobe
//   mem_wen/addr/wdata/wmask      registered request fields, held from issue
//                                 through the completion cycle
//   mem_rvalid, mem_rdata         memory completion and read data
//   dbg_state                     current FSM state (IDLE=0, ISSUE=1, WAIT=2)
//
// Handshake: a request is accepted on the rising edge that ends a cycle in
// which valid && ready are both high. ready depends combinationally on the
// valids and is only ever high in IDLE, for at most one port. Requesters may
// change or drop their request fields freely after the accept edge; the
// arbiter works only from its latched copy. Completion is a single-cycle
// rvalid pulse on the owning port with rdata taken straight from memory.
module mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_wen,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wmask,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic                    d_wen,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  output logic                    mem_ready,
  output logic                    mem_valid,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,

  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   last_d;   // 1 when the d port was granted most recently
  logic   owner_d;  // 1 when the transaction in flight belongs to d
  logic   grant_i;
  logic   grant_d;
  logic   done;

  // Round-robin: on a conflict the port that did not win last time is granted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      grant_i = i_valid && (!d_valid || last_d);
      grant_d = d_valid && (!i_valid || !last_d);
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_d    <= 1'b1;  // makes i the winner of the first conflict
      owner_d   <= 1'b0;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state     <= ISSUE;
            mem_valid <= 1'b1;
            owner_d   <= grant_d;
            last_d    <= grant_d;
            mem_wen   <= grant_d ? d_wen   : i_wen;
            mem_addr  <= grant_d ? d_addr  : i_addr;
            mem_wdata <= grant_d ? d_wdata : i_wdata;
            mem_wmask <= grant_d ? d_wmask : i_wmask;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // Request fields stay untouched here so a memory that commits its
          // write in the completion cycle still sees the accepted operands.
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A memory completion only counts while waiting for one.
  assign done     = (state == WAIT) && mem_rvalid;
  assign i_rvalid = done && !owner_d;
  assign d_rvalid = done && owner_d;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  assign mem_ready = 1'b1;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a small memory responder (reads answer in the cycle
// after the issue strobe, writes one cycle later and commit using the held
// request fields), directed scenario tasks, and a randomized run checked
// against a cycle-timing / shadow-memory reference model.
module tb_mem_arbiter;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int MW = DW / 8;

  logic clk, rst;
  logic          i_valid, i_ready, i_wen, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata, i_rdata;
  logic [MW-1:0] i_wmask;
  logic          d_valid, d_ready, d_wen, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [MW-1:0] d_wmask;
  logic          mem_ready, mem_valid, mem_wen, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] exp_q[$];

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_wen(i_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wmask(i_wmask), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  bit [DW-1:0] mem [0:65535];
  bit [DW-1:0] ref_mem [0:65535];
  bit [DW-1:0] wr_word;
  logic          resp_rvalid = 1'b0;
  logic [DW-1:0] resp_rdata = '0;
  logic          spurious = 1'b0;
  bit            pend = 1'b0;
  bit            preloaded = 1'b0;

  assign mem_rvalid = resp_rvalid | spurious;
  assign mem_rdata  = resp_rdata;

  always @(posedge clk) begin
    resp_rvalid <= 1'b0;
    if (!preloaded) begin
      mem[16'h10] <= 64'hAA;
      preloaded   <= 1'b1;
    end
    if (pend) begin
      pend    <= 1'b0;
      wr_word = mem[mem_addr];
      for (int b = 0; b < MW; b++)
        if (mem_wmask[b]) wr_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
      mem[mem_addr] <= wr_word;
      resp_rvalid   <= 1'b1;
    end else if (mem_valid) begin
      if (mem_wen) pend <= 1'b1;
      else begin
        resp_rvalid <= 1'b1;
        resp_rdata  <= mem[mem_addr];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] m);
    i_valid = v; i_wen = w; i_addr = a; i_wdata = wd; i_wmask = m;
  endtask

  task automatic set_d(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] m);
    d_valid = v; d_wen = w; d_addr = a; d_wdata = wd; d_wmask = m;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_i(0, 0, '0, '0, '0);
    set_d(0, 0, '0, '0, '0);
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL rst_mem_valid got=%b want=0", mem_valid); end
    tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid got=%b%b want=00", i_rvalid, d_rvalid); end
    tests++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0 || mem_wen !== 1'b0) begin fails++; $display("FAIL rst_fields got=%h/%h/%h/%b want=0", mem_addr, mem_wdata, mem_wmask, mem_wen); end
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL mem_ready got=%b want=1", mem_ready); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_i_read();
    tick();
    set_i(1, 0, 16'h10, '0, '0);
    @(negedge clk);
    tests++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin fails++; $display("FAIL ird_ready got=%b%b want=10", i_ready, d_ready); end
    tick();
    set_i(0, 0, '0, '0, '0);
    @(negedge clk);
    tests++; if (mem_valid !== 1'b1 || mem_addr !== 16'h10 || mem_wen !== 1'b0) begin fails++; $display("FAIL ird_issue got=%b/%h/%b want=1/0010/0", mem_valid, mem_addr, mem_wen); end
    tests++; if (i_rvalid !== 1'b0) begin fails++; $display("FAIL ird_early got=%b want=0", i_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== 64'hAA) begin fails++; $display("FAIL ird_done got=%b/%h want=1/aa", i_rvalid, i_rdata); end
    tests++; if (d_rvalid !== 1'b0) begin fails++; $display("FAIL ird_d_rvalid got=%b want=0", d_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b0 || mem_valid !== 1'b0) begin fails++; $display("FAIL ird_after got=%b/%b want=0/0", i_rvalid, mem_valid); end
  endtask

  task automatic test_d_write_read();
    tick();
    set_d(1, 1, 16'h20, 64'h1122334455667788, 8'h0F);
    @(negedge clk);
    tests++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin fails++; $display("FAIL dwr_ready got=%b%b want=01", i_ready, d_ready); end
    tick();
    set_d(0, 0, '0, '0, '0);
    @(negedge clk);
    tests++; if (mem_valid !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== 8'h0F || mem_addr !== 16'h20) begin fails++; $display("FAIL dwr_issue got=%b/%b/%h/%h want=1/1/0f/0020", mem_valid, mem_wen, mem_wmask, mem_addr); end
    tick();
    @(negedge clk);
    tests++; if (d_rvalid !== 1'b0) begin fails++; $display("FAIL dwr_early got=%b want=0", d_rvalid); end
    tick();
    set_d(1, 0, 16'h20, '0, '0);
    @(negedge clk);
    tests++; if (d_rvalid !== 1'b1) begin fails++; $display("FAIL dwr_ack got=%b want=1", d_rvalid); end
    tests++; if (d_ready !== 1'b0) begin fails++; $display("FAIL dwr_busy_ready got=%b want=0", d_ready); end
    tick();
    @(negedge clk);
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL dwr_rd_ready got=%b want=1", d_ready); end
    tick();
    set_d(0, 0, '0, '0, '0);
    tick();
    @(negedge clk);
    tests++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h0000000055667788) begin fails++; $display("FAIL dwr_rdata got=%b/%h want=1/0000000055667788", d_rvalid, d_rdata); end
  endtask

  task automatic test_round_robin();
    int seen;
    int got;
    seen = 0;
    do_reset();
    set_i(1, 0, 16'h10, '0, '0);
    set_d(1, 0, 16'h20, '0, '0);
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(negedge clk);
      tests++; if (i_ready && d_ready) begin fails++; $display("FAIL rr_both_ready got=11 want=not both"); end
      if (i_ready || d_ready) begin
        got = d_ready ? 1 : 0;
        // fresh reset: i first, then strictly alternating
        tests++; if (got != (seen % 2)) begin fails++; $display("FAIL rr_order grant%0d got=%0d want=%0d", seen, got, seen % 2); end
        seen++;
      end
      tick();
    end
    tests++; if (seen != 4) begin fails++; $display("FAIL rr_timeout got=%0d grants want=4", seen); end
    set_i(0, 0, '0, '0, '0);
    set_d(0, 0, '0, '0, '0);
    repeat (4) tick();
  endtask

  task automatic test_addr_change();
    tick();
    set_d(1, 1, 16'h30, 64'hCAFEF00D12345678, 8'hFF);
    @(negedge clk);
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL ac_ready got=%b want=1", d_ready); end
    tick();
    set_d(0, 1, 16'h31, 64'hDEADBEEF00000000, 8'h01);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++; if (mem_addr !== 16'h30 || mem_wdata !== 64'hCAFEF00D12345678 || mem_wmask !== 8'hFF) begin fails++; $display("FAIL ac_hold t+%0d got=%h/%h/%h want=0030/cafef00d12345678/ff", k, mem_addr, mem_wdata, mem_wmask); end
      if (k == 3) begin
        tests++; if (d_rvalid !== 1'b1) begin fails++; $display("FAIL ac_ack got=%b want=1", d_rvalid); end
      end
      tick();
    end
    @(negedge clk);
    tests++; if (mem[16'h30] !== 64'hCAFEF00D12345678 || mem[16'h31] !== 64'h0) begin fails++; $display("FAIL ac_mem got=%h/%h want=cafef00d12345678/0", mem[16'h30], mem[16'h31]); end
  endtask

  task automatic test_reset_in_wait();
    tick();
    set_d(1, 1, 16'h40, 64'h77, 8'hFF);
    @(negedge clk);
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL rw_ready got=%b want=1", d_ready); end
    tick();
    set_d(0, 0, '0, '0, '0);
    tick();
    rst = 1'b0;  // transaction is in WAIT during this cycle
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("FAIL rw_rvalid k%0d got=%b%b want=00", k, i_rvalid, d_rvalid); end
      if (k == 0) begin
        tests++; if (mem_valid !== 1'b0 || mem_addr !== '0) begin fails++; $display("FAIL rw_cleared got=%b/%h want=0/0000", mem_valid, mem_addr); end
      end
      tick();
    end
    set_i(1, 0, 16'h10, '0, '0);
    @(negedge clk);
    tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL rw_iready got=%b want=1", i_ready); end
    tick();
    set_i(0, 0, '0, '0, '0);
    tick();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== 64'hAA) begin fails++; $display("FAIL rw_iread got=%b/%h want=1/aa", i_rvalid, i_rdata); end
  endtask

  task automatic test_spurious();
    tick();
    spurious = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_valid !== 1'b0) begin fails++; $display("FAIL sp_idle k%0d got=%b%b%b want=000", k, i_rvalid, d_rvalid, mem_valid); end
      tick();
    end
    spurious = 1'b0;
    set_i(1, 0, 16'h10, '0, '0);
    @(negedge clk);
    tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL sp_ready got=%b want=1", i_ready); end
    tick();
    set_i(0, 0, '0, '0, '0);
    tick();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== 64'hAA) begin fails++; $display("FAIL sp_read got=%b/%h want=1/aa", i_rvalid, i_rdata); end
  endtask

  // Reference: a port may be granted once the previous transaction's fixed
  // busy window has passed; completions land at a fixed offset from accept;
  // read data comes from a shadow memory updated with the accepted writes.
  task automatic test_random();
    int nf, acc_c, comp_c, last_p, comp_p;
    logic comp_rd, idle, exp_gi, exp_gd, w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, want, got;
    logic [MW-1:0] m;
    exp_q.delete();
    set_i(0, 0, '0, '0, '0);
    set_d(0, 0, '0, '0, '0);
    do_reset();
    nf = cyc; acc_c = -100; comp_c = -100; last_p = 1; comp_p = 0; comp_rd = 1'b0;
    for (int n = 0; n < 410; n++) begin
      if (n < 400) begin
        if (!i_valid && $urandom_range(0, 2) != 0)
          set_i(1, 1'($urandom_range(0, 1)), 16'h100 + 16'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        if (!d_valid && $urandom_range(0, 2) != 0)
          set_d(1, 1'($urandom_range(0, 1)), 16'h100 + 16'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      end
      @(negedge clk);
      idle   = (cyc >= nf);
      exp_gi = idle && i_valid && (!d_valid || last_p == 1);
      exp_gd = idle && d_valid && (!i_valid || last_p == 0);
      tests++; if (i_ready !== exp_gi || d_ready !== exp_gd) begin fails++; $display("FAIL rnd_ready cyc%0d got=%b%b want=%b%b", cyc, i_ready, d_ready, exp_gi, exp_gd); end
      tests++; if (mem_valid !== (cyc == acc_c + 1)) begin fails++; $display("FAIL rnd_mem_valid cyc%0d got=%b want=%b", cyc, mem_valid, cyc == acc_c + 1); end
      tests++; if (i_rvalid !== (cyc == comp_c && comp_p == 0) || d_rvalid !== (cyc == comp_c && comp_p == 1)) begin fails++; $display("FAIL rnd_rvalid cyc%0d got=%b%b want=%b%b", cyc, i_rvalid, d_rvalid, cyc == comp_c && comp_p == 0, cyc == comp_c && comp_p == 1); end
      if (cyc == comp_c && comp_rd && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = comp_p ? d_rdata : i_rdata;
        tests++; if (got !== want) begin fails++; $display("FAIL rnd_rdata cyc%0d got=%h want=%h", cyc, got, want); end
      end
      if (exp_gi || exp_gd) begin
        w  = exp_gd ? d_wen   : i_wen;
        a  = exp_gd ? d_addr  : i_addr;
        wd = exp_gd ? d_wdata : i_wdata;
        m  = exp_gd ? d_wmask : i_wmask;
        acc_c  = cyc;
        comp_c = cyc + (w ? 3 : 2);
        nf     = cyc + (w ? 4 : 3);
        last_p = exp_gd ? 1 : 0;
        comp_p = last_p;
        comp_rd = !w;
        if (w) begin
          for (int b = 0; b < MW; b++)
            if (m[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          exp_q.push_back(ref_mem[a]);
        end
      end
      tick();
      if (exp_gi) i_valid = 1'b0;
      if (exp_gd) d_valid = 1'b0;
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rnd_drain got=%0d pending want=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    set_i(0, 0, '0, '0, '0);
    set_d(0, 0, '0, '0, '0);
    test_reset();
    test_i_read();
    test_d_write_read();
    test_round_robin();
    test_addr_change();
    test_reset_in_wait();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
